rti_pop_unit: RTL and testbench
===============================

Name: rti_pop_unit

Overview:
- Datapath stage directly downstream of the RTI sequencing controller.
- Consumes `rti_pop`, `pop_segment`, `write_flags`, `write_pc` and `inc_pc`.
- Owns the stack pointer (SP). Issues one stack read per pop cycle and captures the returned words into flags / PC-high / PC-low holding registers.
- Drives the one-cycle write-back strobes for the flags register and the fetch-stage PC.

Parameters:
- `DATA_W`, 16, width of one stack word; PC width is 2*`DATA_W`.
- `ADDR_W`, 12, stack address / SP width.
- `FLAG_W`, 4, number of architectural flag bits (low bits of the flags word).
- `STACK_TOP`, 2^`ADDR_W`-1, SP reset value; stack grows downward.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rti_pop`  in  1  pop request for this cycle.
- `pop_segment`  in  2  destination of the word popped this cycle: 00 flags, 01 PC-high, 10 PC-low, 11 none.
- `write_flags`  in  1  commit captured flags.
- `write_pc`  in  1  commit assembled PC.
- `inc_pc`  in  1  add 1 to the PC being committed (immediate-instruction skip).
- `push_dec`  in  1  push path decremented the stack this cycle.
- `mem_rd_en`  out  1  stack read strobe.
- `mem_addr`  out  `ADDR_W`  stack read address.
- `mem_rdata`  in  `DATA_W`  read data, valid exactly 1 cycle after `mem_rd_en`.
- `sp`  out  `ADDR_W`  current stack pointer.
- `flags_out`  out  `FLAG_W`  flags to write back.
- `flags_we`  out  1  flags write strobe.
- `pc_out`  out  2*`DATA_W`  PC to load.
- `pc_we`  out  1  PC load strobe.
- `underflow`  out  1  sticky: pop attempted at `STACK_TOP`.
- `seq_err`  out  1  sticky: `write_pc` with a PC half not captured, or `push_dec` colliding with `rti_pop`.

Behaviour:

Reset (`rst`=0, asynchronous):
- `sp`=`STACK_TOP`.
- All holding registers, valid bits and outputs = 0.
- Any pop in flight is discarded; `mem_rdata` returning in the first cycle after reset release is ignored.

Pop issue, cycle N, `rti_pop`=1 and `sp`!=`STACK_TOP`:
- `mem_rd_en`=1 and `mem_addr`=`sp`+1 combinationally.
- `sp`<=`sp`+1.
- `pop_segment` is registered as `seg_q`, with `pend_q`=1.

Pop at `sp`=`STACK_TOP`:
- No read, `sp` unchanged.
- `underflow`<=1 (sticky until reset).
- The target segment's valid bit is not set.

Capture, cycle N+1, when `pend_q`=1 (`mem_rdata` routed by `seg_q`):
- 00: `flags_q`<=`mem_rdata`[`FLAG_W`-1:0], `fv`<=1.
- 01: `pchi_q`<=`mem_rdata`, `hv`<=1.
- 10: `pclo_q`<=`mem_rdata`, `lv`<=1.
- 11: data discarded.

Back-to-back pops:
- Issue and capture pipeline overlap; one pop per cycle is sustained.

`write_flags`:
- `flags_we`=1 for exactly the cycle `write_flags` is high (combinational pass-through of the strobe).
- `flags_out` = `flags_q`, or the captured `mem_rdata` when the flags capture occurs in the same cycle (bypass).
- Clears `fv` at the clock edge.

`write_pc`:
- `pc_we`=1 in the same cycle.
- `pc_out` = {hi,lo} + `inc_pc`. Each half is bypassed from `mem_rdata` if it is being captured that cycle.
- Arithmetic is modulo 2^(2*`DATA_W`): `FFFF_FFFF`+1 = `0000_0000`.
- Clears `hv` and `lv`.
- If either half was not captured: `seq_err`<=1. The strobe still fires, using the stale register value.

Idle outputs:
- `flags_out`/`pc_out` hold their last values; strobes are 0.

`push_dec` alone:
- `sp`<=`sp`-1. Wraps from 0 to `STACK_TOP` (overflow is the push stage's check).

`push_dec` and `rti_pop` in the same cycle:
- The pop wins; `push_dec` is ignored and `seq_err`<=1.

Extra strobes:
- `write_flags`/`write_pc` with no preceding pop are legal: they re-issue the held values.

Test Plan:
- Reset, `push_dec` x3 → `sp`=`FFC`. Pop sequence seg 00, 01, 10 on consecutive cycles with memory `[FFD]`=`000A`, `[FFE]`=`1234`, `[FFF]`=`5678`; then `write_flags`, then `write_pc`, `inc_pc`=0 → `mem_addr` `FFD`/`FFE`/`FFF`; `flags_out`=`A` with `flags_we` one cycle; `pc_out`=`12345678` with `pc_we` one cycle; `sp`=`FFF`.
- Same sequence with `inc_pc`=1 and halves `FFFF`/`FFFF` → `pc_out`=`00000000`, no error.
- `write_flags` asserted in the capture cycle of the flags pop (`mem_rdata`=`0005`) → `flags_out`=`5` that cycle via bypass.
- Pop at `sp`=`FFF` → `mem_rd_en`=0, `sp` stays `FFF`, `underflow`=1. A later `write_pc` without a PC-low capture → `seq_err`=1.
- `push_dec` and `rti_pop` together at `sp`=`FF0` → read at `FF1`, `sp`=`FF1`, `seq_err`=1.
- Assert `rst`=0 between the PC-high issue and its capture → after release, `sp`=`FFF`, all valids 0, the returning `mem_rdata` is ignored, and no strobes fire.

Source files
------------

// File: rtl/rti_pop_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rti_pop_unit: owns the stack pointer and pops flags / PC-high / PC-low   |
// | words for return-from-interrupt, driving flags and PC write-back strobes.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rti_pop_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int FLAG_W = 4,
  parameter logic [ADDR_W-1:0] STACK_TOP = {ADDR_W{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rti_pop,
  input  logic [1:0]            pop_segment,
  input  logic                  write_flags,
  input  logic                  write_pc,
  input  logic                  inc_pc,
  input  logic                  push_dec,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [ADDR_W-1:0]     sp,
  output logic [FLAG_W-1:0]     flags_out,
  output logic                  flags_we,
  output logic [2*DATA_W-1:0]   pc_out,
  output logic                  pc_we,
  output logic                  underflow,
  output logic                  seq_err
);

  localparam logic [1:0] c_SEG_FLAGS = 2'b00;
  localparam logic [1:0] c_SEG_PCHI  = 2'b01;
  localparam logic [1:0] c_SEG_PCLO  = 2'b10;

  logic [ADDR_W-1:0]   r_sp;
  logic [1:0]          r_seg;
  logic                r_pend;
  logic [FLAG_W-1:0]   r_flags;
  logic [DATA_W-1:0]   r_pchi;
  logic [DATA_W-1:0]   r_pclo;
  logic                r_fv;
  logic                r_hv;
  logic                r_lv;
  logic [FLAG_W-1:0]   r_flags_last;
  logic [2*DATA_W-1:0] r_pc_last;
  logic                r_underflow;
  logic                r_seq_err;

  logic                w_at_top;
  logic                w_issue;
  logic                w_cap_flags;
  logic                w_cap_hi;
  logic                w_cap_lo;
  logic [FLAG_W-1:0]   w_flags_val;
  logic [DATA_W-1:0]   w_hi_val;
  logic [DATA_W-1:0]   w_lo_val;
  logic [2*DATA_W-1:0] w_pc_val;
  logic                w_pc_incomplete;
  logic                w_collide;

  assign w_at_top    = (r_sp == STACK_TOP);
  assign w_issue     = rti_pop && !w_at_top;
  assign w_cap_flags = r_pend && (r_seg == c_SEG_FLAGS);
  assign w_cap_hi    = r_pend && (r_seg == c_SEG_PCHI);
  assign w_cap_lo    = r_pend && (r_seg == c_SEG_PCLO);
  assign w_collide   = rti_pop && push_dec;

  // Words arriving this cycle bypass the holding registers so a commit can
  // land in the same cycle as the final capture.
  always_comb begin
    w_flags_val     = w_cap_flags ? mem_rdata[FLAG_W-1:0] : r_flags;
    w_hi_val        = w_cap_hi ? mem_rdata : r_pchi;
    w_lo_val        = w_cap_lo ? mem_rdata : r_pclo;
    w_pc_val        = {w_hi_val, w_lo_val} + {{(2*DATA_W-1){1'b0}}, inc_pc};
    w_pc_incomplete = !((r_hv || w_cap_hi) && (r_lv || w_cap_lo));
  end

  assign mem_rd_en = w_issue;
  assign mem_addr  = r_sp + 1'b1;
  assign sp        = r_sp;
  assign flags_we  = write_flags;
  assign pc_we     = write_pc;
  assign flags_out = write_flags ? w_flags_val : r_flags_last;
  assign pc_out    = write_pc ? w_pc_val : r_pc_last;
  assign underflow = r_underflow;
  assign seq_err   = r_seq_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp         <= STACK_TOP;
      r_seg        <= 2'b00;
      r_pend       <= 1'b0;
      r_flags      <= '0;
      r_pchi       <= '0;
      r_pclo       <= '0;
      r_fv         <= 1'b0;
      r_hv         <= 1'b0;
      r_lv         <= 1'b0;
      r_flags_last <= '0;
      r_pc_last    <= '0;
      r_underflow  <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      r_pend <= w_issue;
      r_seg  <= pop_segment;

      if (w_issue) begin
        r_sp <= r_sp + 1'b1;
      end else if (push_dec && !rti_pop) begin
        r_sp <= (r_sp == '0) ? STACK_TOP : r_sp - 1'b1;
      end

      if (w_cap_flags) r_flags <= mem_rdata[FLAG_W-1:0];
      if (w_cap_hi)    r_pchi  <= mem_rdata;
      if (w_cap_lo)    r_pclo  <= mem_rdata;

      // A commit consumes the value, including one captured in the same cycle.
      if (write_flags)      r_fv <= 1'b0;
      else if (w_cap_flags) r_fv <= 1'b1;
      if (write_pc)         r_hv <= 1'b0;
      else if (w_cap_hi)    r_hv <= 1'b1;
      if (write_pc)         r_lv <= 1'b0;
      else if (w_cap_lo)    r_lv <= 1'b1;

      if (write_flags) r_flags_last <= w_flags_val;
      if (write_pc)    r_pc_last    <= w_pc_val;

      if (rti_pop && w_at_top) r_underflow <= 1'b1;
      if (w_collide || (write_pc && w_pc_incomplete)) r_seq_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rti_pop_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rti_pop_unit: directed self-checking bench for rti_pop_unit.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_rti_pop_unit;

  logic        clk;
  logic        rst;
  logic        rti_pop;
  logic [1:0]  pop_segment;
  logic        write_flags;
  logic        write_pc;
  logic        inc_pc;
  logic        push_dec;
  logic        mem_rd_en;
  logic [11:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [11:0] sp;
  logic [3:0]  flags_out;
  logic        flags_we;
  logic [31:0] pc_out;
  logic        pc_we;
  logic        underflow;
  logic        seq_err;

  int passed = 0;
  int total  = 0;

  logic [15:0] mem [0:4095];

  rti_pop_unit dut (
    .clk         (clk),
    .rst         (rst),
    .rti_pop     (rti_pop),
    .pop_segment (pop_segment),
    .write_flags (write_flags),
    .write_pc    (write_pc),
    .inc_pc      (inc_pc),
    .push_dec    (push_dec),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .sp          (sp),
    .flags_out   (flags_out),
    .flags_we    (flags_we),
    .pc_out      (pc_out),
    .pc_we       (pc_we),
    .underflow   (underflow),
    .seq_err     (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous stack memory: one-cycle read latency, junk when not reading.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else           mem_rdata <= 16'hDEAD;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rti_pop = 0; pop_segment = 2'b11; write_flags = 0;
    write_pc = 0; inc_pc = 0; push_dec = 0;
  endtask

  task automatic do_reset;
    idle();
    rst = 0;
    tick();
    tick();
    rst = 1;
    tick();
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      idle(); push_dec = 1; tick();
    end
    idle();
  endtask

  initial begin
    mem_rdata = 16'h0000;
    do_reset();
    #1;
    chk("rst_sp", {20'd0, sp}, 32'h0000_0FFF);
    chk("rst_flags_out", {28'd0, flags_out}, 32'h0);
    chk("rst_pc_out", pc_out, 32'h0);
    chk("rst_strobes", {30'd0, flags_we, pc_we}, 32'h0);
    chk("rst_sticky", {30'd0, underflow, seq_err}, 32'h0);

    // Basic three-word pop then separate commits.
    push_n(3);
    chk("push3_sp", {20'd0, sp}, 32'h0000_0FFC);
    mem[12'hFFD] = 16'h000A; mem[12'hFFE] = 16'h1234; mem[12'hFFF] = 16'h5678;
    rti_pop = 1; pop_segment = 2'b00; #1;
    chk("pop0_rd_en", {31'd0, mem_rd_en}, 32'h1);
    chk("pop0_addr", {20'd0, mem_addr}, 32'h0000_0FFD);
    tick();
    pop_segment = 2'b01; #1;
    chk("pop1_addr", {20'd0, mem_addr}, 32'h0000_0FFE);
    tick();
    pop_segment = 2'b10; #1;
    chk("pop2_addr", {20'd0, mem_addr}, 32'h0000_0FFF);
    tick();
    idle(); write_flags = 1; #1;
    chk("wf_flags_out", {28'd0, flags_out}, 32'hA);
    chk("wf_flags_we", {31'd0, flags_we}, 32'h1);
    chk("wf_pc_we", {31'd0, pc_we}, 32'h0);
    tick();
    idle(); write_pc = 1; #1;
    chk("wp_pc_out", pc_out, 32'h1234_5678);
    chk("wp_pc_we", {31'd0, pc_we}, 32'h1);
    chk("wp_flags_we", {31'd0, flags_we}, 32'h0);
    tick();
    idle(); #1;
    chk("t1_sp", {20'd0, sp}, 32'h0000_0FFF);
    chk("t1_idle_strobes", {30'd0, flags_we, pc_we}, 32'h0);
    chk("t1_hold_flags", {28'd0, flags_out}, 32'hA);
    chk("t1_hold_pc", pc_out, 32'h1234_5678);
    chk("t1_seq_err", {31'd0, seq_err}, 32'h0);

    // PC wrap with inc_pc, low half bypassed in its capture cycle.
    push_n(3);
    mem[12'hFFD] = 16'h0003; mem[12'hFFE] = 16'hFFFF; mem[12'hFFF] = 16'hFFFF;
    rti_pop = 1; pop_segment = 2'b00; tick();
    pop_segment = 2'b01; tick();
    pop_segment = 2'b10; tick();
    idle(); write_pc = 1; inc_pc = 1; #1;
    chk("wrap_pc_out", pc_out, 32'h0000_0000);
    chk("wrap_pc_we", {31'd0, pc_we}, 32'h1);
    tick();
    idle(); #1;
    chk("wrap_seq_err", {31'd0, seq_err}, 32'h0);
    chk("wrap_hold_pc", pc_out, 32'h0000_0000);

    // Flags bypass in the capture cycle.
    push_n(1);
    mem[12'hFFF] = 16'h0005;
    rti_pop = 1; pop_segment = 2'b00; tick();
    idle(); write_flags = 1; #1;
    chk("byp_flags_out", {28'd0, flags_out}, 32'h5);
    chk("byp_flags_we", {31'd0, flags_we}, 32'h1);
    tick();

    // Underflow, then write_pc without captured halves.
    idle(); rti_pop = 1; pop_segment = 2'b10; #1;
    chk("uf_rd_en", {31'd0, mem_rd_en}, 32'h0);
    tick();
    idle(); #1;
    chk("uf_sp", {20'd0, sp}, 32'h0000_0FFF);
    chk("uf_flag", {31'd0, underflow}, 32'h1);
    chk("uf_no_seq_err", {31'd0, seq_err}, 32'h0);
    write_pc = 1; #1;
    chk("stale_pc_out", pc_out, 32'hFFFF_FFFF);
    tick();
    idle(); #1;
    chk("stale_seq_err", {31'd0, seq_err}, 32'h1);

    // push_dec colliding with rti_pop.
    do_reset();
    push_n(15);
    chk("ff0_sp", {20'd0, sp}, 32'h0000_0FF0);
    rti_pop = 1; push_dec = 1; pop_segment = 2'b11; #1;
    chk("col_rd_en", {31'd0, mem_rd_en}, 32'h1);
    chk("col_addr", {20'd0, mem_addr}, 32'h0000_0FF1);
    tick();
    idle(); #1;
    chk("col_sp", {20'd0, sp}, 32'h0000_0FF1);
    chk("col_seq_err", {31'd0, seq_err}, 32'h1);
    chk("col_underflow", {31'd0, underflow}, 32'h0);

    // Reset between PC-high issue and its capture.
    do_reset();
    push_n(2);
    mem[12'hFFE] = 16'hABCD;
    rti_pop = 1; pop_segment = 2'b01; tick();
    idle(); rst = 0; #1;
    chk("mid_rst_sp", {20'd0, sp}, 32'h0000_0FFF);
    #1 rst = 1; #1;
    chk("mid_rdata_in_flight", {16'd0, mem_rdata}, 32'h0000_ABCD);
    tick();
    #1;
    chk("mid_sp", {20'd0, sp}, 32'h0000_0FFF);
    chk("mid_strobes", {30'd0, flags_we, pc_we}, 32'h0);
    chk("mid_seq_err_clear", {31'd0, seq_err}, 32'h0);
    write_pc = 1; #1;
    chk("mid_pc_ignored", pc_out, 32'h0000_0000);
    tick();
    idle(); #1;
    chk("mid_valids_clear", {31'd0, seq_err}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
